// File: rtl/nar_pkg.sv
// Shared NAR-Net datapath definitions: control states, default widths, saturation bounds.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package nar_pkg;

   // Control states shared by the streaming datapath blocks
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Default operand, accumulator and output widths
   localparam int DATA_W = 8;
   localparam int ACC_W  = 24;
   localparam int OUT_W  = 8;

   // Largest value of a w-bit two's complement number, widened to 64 bits
   function automatic logic signed [63:0] sat_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Smallest value of a w-bit two's complement number, widened to 64 bits
   function automatic logic signed [63:0] sat_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/mac_sat_round.sv
// Requantiser: round-half-up arithmetic shift of the accumulator, then clamp to OUT_W.
// Latency: combinational.
// Backpressure: none; pure function of acc.
module mac_sat_round
   import nar_pkg::*;
#(
   parameter int ACC_W      = 24,
   parameter int OUT_W      = 8,
   parameter int FRAC_SHIFT = 4
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] q
);

   localparam logic signed [63:0] Q_HI = sat_hi(OUT_W);
   localparam logic signed [63:0] Q_LO = sat_lo(OUT_W);

   // One guard bit so adding the rounding half can never wrap
   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] shifted;
   logic signed [63:0]    wide;

   assign ext = {acc[ACC_W-1], acc};

   generate
      if (FRAC_SHIFT > 0) begin : g_round
         localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
         logic signed [ACC_W:0] biased;
         assign biased  = ext + HALF;
         assign shifted = biased >>> FRAC_SHIFT;
      end else begin : g_no_round
         assign shifted = ext;
      end
   endgenerate

   assign wide = {{(63 - ACC_W){shifted[ACC_W]}}, shifted};

   // Clamp the shifted value into the signed output range
   always_comb begin
      q = wide[OUT_W-1:0];
      if (wide > Q_HI) begin
         q = Q_HI[OUT_W-1:0];
      end else if (wide < Q_LO) begin
         q = Q_LO[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate of len operand pairs with saturating accumulator and requantised result.
// Latency: one term per cycle; out_valid rises the edge after the last accepted pair (1 cycle for len==0).
// Backpressure: in_ready only in ACCUM; result held stable in DONE until out_ready.
module mac_accumulator
   import nar_pkg::*;
#(
   parameter int DATA_W     = nar_pkg::DATA_W,
   parameter int ACC_W      = nar_pkg::ACC_W,
   parameter int LEN_W      = 8,
   parameter int OUT_W      = nar_pkg::OUT_W,
   parameter int FRAC_SHIFT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic        [LEN_W-1:0]  len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic signed [ACC_W-1:0]  acc_raw,
   output logic                     overflow
);

   localparam int PROD_W = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_hi(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_lo(ACC_W));

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic        [LEN_W-1:0]  count;
   logic                     ovf_q;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W:0]    sum;
   logic                     sum_ovf;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [OUT_W-1:0]  rq_next;
   logic                     take;

   assign take = in_valid && in_ready;

   // Full-precision product, then add with one guard bit to catch wrap
   assign prod = a * b;
   assign sum  = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};

   // The guard bit disagreeing with the accumulator sign bit means the add left the ACC_W range
   always_comb begin
      sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
      acc_next = sum[ACC_W-1:0];
      if (sum_ovf) begin
         acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   // Requantise the value the accumulator is about to hold so out_data lands with out_valid
   mac_sat_round #(
      .ACC_W      (ACC_W),
      .OUT_W      (OUT_W),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_sat_round (
      .acc (acc_next),
      .q   (rq_next)
   );

   assign acc_raw  = acc;
   assign overflow = ovf_q;

   // Control FSM with registered handshake outputs and result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         ovf_q     <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  ovf_q <= 1'b0;
                  if (len != '0) begin
                     count    <= len;
                     in_ready <= 1'b1;
                     state    <= ACCUM;
                  end else begin
                     // Empty dot product: the result is zero, and zero requantises to zero
                     out_data  <= '0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            ACCUM: begin
               if (take) begin
                  acc   <= acc_next;
                  count <= count - 1'b1;
                  if (sum_ovf) begin
                     ovf_q <= 1'b1;
                  end
                  if (count == LEN_W'(1)) begin
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_data  <= rq_next;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: random dot products on a default and a 16-bit-accumulator instance.
// Latency: checks out_valid the edge after the last accepted term.
// Backpressure: exercises in_valid gaps and delayed out_ready.
module tb_mac_accumulator;

   localparam int DW = 8;
   localparam int LW = 8;
   localparam int OW = 8;
   localparam int FS = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic        [LW-1:0] len = '0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] a = '0;
   logic signed [DW-1:0] b = '0;
   logic                 out_ready = 1'b0;

   logic                 in_ready0, out_valid0, overflow0;
   logic signed [OW-1:0] out_data0;
   logic signed [23:0]   acc_raw0;
   logic                 in_ready1, out_valid1, overflow1;
   logic signed [OW-1:0] out_data1;
   logic signed [15:0]   acc_raw1;

   int checks = 0;
   int errors = 0;
   int qa[$];
   int qb[$];

   always #5 clk = ~clk;

   mac_accumulator #(.DATA_W(DW), .ACC_W(24), .LEN_W(LW), .OUT_W(OW), .FRAC_SHIFT(FS)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .acc_raw(acc_raw0), .overflow(overflow0));

   mac_accumulator #(.DATA_W(DW), .ACC_W(16), .LEN_W(LW), .OUT_W(OW), .FRAC_SHIFT(FS)) dut16 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .acc_raw(acc_raw1), .overflow(overflow1));

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain integer sum with clamp to the w-bit range, then round-half-up and clamp
   function automatic void model(input int w, output longint acc_o, output longint q_o, output bit ov_o);
      longint hi = (longint'(1) <<< (w - 1)) - 1;
      longint lo = -(longint'(1) <<< (w - 1));
      longint acc = 0;
      longint r;
      ov_o = 1'b0;
      foreach (qa[i]) begin
         acc = acc + longint'(qa[i]) * longint'(qb[i]);
         if (acc > hi) begin acc = hi; ov_o = 1'b1; end
         if (acc < lo) begin acc = lo; ov_o = 1'b1; end
      end
      r = (acc + (longint'(1) <<< (FS - 1))) >>> FS;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      acc_o = acc;
      q_o   = r;
   endfunction

   task automatic fill(input int n, input bit extreme);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
         if (extreme) begin
            qa.push_back(($urandom_range(0, 1) == 1) ? 127 : -128);
            qb.push_back(($urandom_range(0, 1) == 1) ? 127 : -128);
         end else begin
            qa.push_back(int'($urandom_range(0, 255)) - 128);
            qb.push_back(int'($urandom_range(0, 255)) - 128);
         end
      end
   endtask

   task automatic check_results(input string tag);
      longint ea0, eq0, ea1, eq1;
      bit eo0, eo1;
      model(24, ea0, eq0, eo0);
      model(16, ea1, eq1, eo1);
      check({tag, "_acc24"}, longint'(acc_raw0), ea0);
      check({tag, "_out24"}, longint'(out_data0), eq0);
      check({tag, "_ovf24"}, longint'(overflow0), longint'(eo0));
      check({tag, "_acc16"}, longint'(acc_raw1), ea1);
      check({tag, "_out16"}, longint'(out_data1), eq1);
      check({tag, "_ovf16"}, longint'(overflow1), longint'(eo1));
   endtask

   // mode 0: in_valid always high, 1: alternating, 2: random gaps
   task automatic run_dot(input string tag, input int n, input int mode, input int hold, input bit inj);
      int idx = 0;
      int budget = 0;
      bit tog = 1'b1;
      bit v;
      bit acc_now;
      longint held_d, held_a;
      @(negedge clk);
      start = 1'b1;
      len = LW'(n);
      @(negedge clk);
      start = 1'b0;
      len = '0;
      if (n == 0) begin
         check({tag, "_len0_inrdy"}, longint'(in_ready0), 0);
      end
      while (idx < n && budget < 1000) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         in_valid = v;
         a = DW'(qa[idx]);
         b = DW'(qb[idx]);
         if (inj && idx == 1) begin
            start = 1'b1;
            len = LW'(7);
         end
         acc_now = v && in_ready0;
         @(negedge clk);
         start = 1'b0;
         len = '0;
         if (acc_now) idx++;
         budget++;
      end
      in_valid = 1'b0;
      if (budget >= 1000) check({tag, "_timeout"}, idx, n);
      check({tag, "_lat_vld"}, longint'(out_valid0), 1);
      check({tag, "_lat_vld16"}, longint'(out_valid1), 1);
      check({tag, "_done_inrdy"}, longint'(in_ready0), 0);
      check_results(tag);
      held_d = longint'(out_data0);
      held_a = longint'(acc_raw0);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         if (inj && h == 0) begin
            start = 1'b1;
            len = LW'(7);
         end
         @(negedge clk);
         start = 1'b0;
         len = '0;
         check({tag, "_hold_vld"}, longint'(out_valid0), 1);
         check({tag, "_hold_dat"}, longint'(out_data0), held_d);
         check({tag, "_hold_acc"}, longint'(acc_raw0), held_a);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_idle_vld"}, longint'(out_valid0), 0);
      check({tag, "_idle_inrdy"}, longint'(in_ready0), 0);
      if (inj) check_results({tag, "_inj"});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_inrdy"}, longint'(in_ready0), 0);
      check({tag, "_vld"}, longint'(out_valid0), 0);
      check({tag, "_acc"}, longint'(acc_raw0), 0);
      check({tag, "_dat"}, longint'(out_data0), 0);
      check({tag, "_ovf"}, longint'(overflow0), 0);
      check({tag, "_acc16"}, longint'(acc_raw1), 0);
      check({tag, "_dat16"}, longint'(out_data1), 0);
   endtask

   initial begin
      #1;
      check_zero("rst0");
      #12;
      rst = 1'b0;

      // small mixed-sign sum and its negation
      qa = '{2, 4, -1};  qb = '{3, 5, 6};
      run_dot("t1pos", 3, 0, 0, 1'b0);
      check("t1_acc_const", longint'(acc_raw0), 20);
      check("t1_out_const", longint'(out_data0), 1);
      qa = '{2, 4, -1};  qb = '{-3, -5, -6};
      run_dot("t1neg", 3, 0, 0, 1'b0);
      check("t1n_out_const", longint'(out_data0), -1);

      // output clamp on the wide instance, accumulator clamp on the narrow one
      qa = '{127, 127, 127, 127};  qb = '{127, 127, 127, 127};
      run_dot("t2max", 4, 0, 0, 1'b0);
      check("t2_acc_const", longint'(acc_raw0), 64516);
      qa = '{-128, -128};  qb = '{-128, -128};
      run_dot("t2sat", 2, 0, 0, 1'b0);
      check("t2_acc16_const", longint'(acc_raw1), 32767);
      check("t2_ovf16_const", longint'(overflow1), 1);

      // alternating in_valid, stalled output
      fill(5, 1'b0);
      run_dot("t3gap", 5, 1, 4, 1'b0);

      // empty dot product
      qa.delete();  qb.delete();
      run_dot("t4len0", 0, 0, 1, 1'b0);

      // async reset after two of five accepted terms
      fill(5, 1'b0);
      @(negedge clk);
      start = 1'b1;  len = LW'(5);
      @(negedge clk);
      start = 1'b0;  len = '0;
      in_valid = 1'b1;  a = DW'(qa[0]);  b = DW'(qb[0]);
      @(negedge clk);
      a = DW'(qa[1]);  b = DW'(qb[1]);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_zero("t5rst");
      @(negedge clk);
      rst = 1'b0;
      qa = '{3};  qb = '{4};
      run_dot("t5new", 1, 0, 0, 1'b0);
      check("t5_acc_const", longint'(acc_raw0), 12);
      check("t5_out_const", longint'(out_data0), 1);

      // start pulses during ACCUM and DONE are ignored
      fill(3, 1'b0);
      run_dot("t6inj", 3, 0, 2, 1'b1);

      // randomized sweep
      for (int t = 0; t < 40; t++) begin
         int n;
         n = $urandom_range(0, 12);
         fill(n, ($urandom_range(0, 3) == 0));
         run_dot($sformatf("rnd%0d", t), n, $urandom_range(0, 2), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
